multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Control unit of the multicycle MIPS core; consumes op/funct from the datapath instruction register and the ALU zero flag.
// - Drives all datapath enables and mux selects per cycle: Moore main FSM plus a combinational ALU decoder.
// - Instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
// PARAMETERS
// - STATE_W      4       width of the state register; holds 12 states
// - ALU_DEFAULT  3'b010  alu_control driven for an unknown R-type funct (add)
// PORTS
// - clk          in   1  single clock; all state updates on posedge
// - reset        in   1  synchronous, active-low; 0 at posedge forces FETCH
// - op           in   6  instr[31:26], held stable by the IR after FETCH
// - funct        in   6  instr[5:0]
// - zero         in   1  ALU result == 0
// - i_or_d       out  1  memory address select: 0 = PC, 1 = ALUOut
// - mem_write    out  1  data memory write enable
// - ir_write     out  1  instruction register load enable
// - reg_dst      out  1  register file write address: 0 = rt, 1 = rd
// - mem_to_reg   out  1  register file write data: 0 = ALUOut, 1 = Data
// - reg_write    out  1  register file write enable
// - alu_src_a    out  1  ALU A: 0 = PC, 1 = A register
// - alu_src_b    out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
// - pc_src       out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
// - pc_en        out  1  PC load = pc_write | (branch & zero)
// - alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
// BEHAVIOUR
// - States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQ 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
// - Transitions:
//   - FETCH->DECODE.
//   - DECODE by op: 100011 (lw) / 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BEQ; 001000 -> ADDIEXEC; 000010 -> JUMP; any other op -> FETCH (instruction dropped).
//   - MEMADR: lw -> MEMRD, sw -> MEMWR. MEMRD->MEMWB. EXECUTE->ALUWB. ADDIEXEC->ADDIWB.
//   - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, JUMP -> FETCH. Encodings 12-15 -> FETCH.
// - op is decoded only in DECODE and MEMADR; funct is used only in EXECUTE.
// - Outputs not listed for a state are 0; aluop (internal, 2 bits) = 00 unless listed.
//   - FETCH: ir_write=1, pc_write=1, alu_src_b=01
//   - DECODE: alu_src_b=11
//   - MEMADR / ADDIEXEC: alu_src_a=1, alu_src_b=10
//   - MEMRD: i_or_d=1
//   - MEMWR: i_or_d=1, mem_write=1
//   - MEMWB: reg_write=1, mem_to_reg=1
//   - EXECUTE: alu_src_a=1, aluop=10
//   - ALUWB: reg_write=1, reg_dst=1
//   - ADDIWB: reg_write=1
//   - BEQ: alu_src_a=1, aluop=01, pc_src=01, branch=1
//   - JUMP: pc_src=10, pc_write=1
// - ALU decode: aluop 00 -> 010; 01 -> 110; 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, else ALU_DEFAULT. aluop 11 -> 010.
// - Latency in cycles, FETCH to return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
// - Reset: state <= FETCH at the next posedge, including mid-instruction. The following cycle shows the FETCH output vector: ir_write=1, pc_en=1, alu_src_b=01, alu_control=010, all other outputs 0.
// - Outputs are decoded from state with no register stage. pc_en and alu_control also depend combinationally on zero and funct.
// - No X is driven on any output for any op/funct/state.
// STRUCTURE
// - Shared include mips_defs.vh holds:
//   - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
//   - funct constants
//   - ALU control codes
//   - state encodings S_FETCH..S_JUMP
// - One sub-module, alu_decoder (aluop, funct -> alu_control), purely combinational.
// - The top level holds the state register, next-state logic and the output decode.
// TESTING
// - reset=0 for 2 clocks, then 1 -> first cycle after release: ir_write=1, pc_en=1, alu_src_b=01, alu_control=010.
// - op=100011 -> states 0,1,2,3,4,0. MEMRD has i_or_d=1; MEMWB has reg_write=1 and mem_to_reg=1.
// - op=101011 -> states 0,1,2,5,0. mem_write=1 in MEMWR only; reg_write is never 1.
// - op=0, funct sweep {100000,100010,100100,100101,101010,000000} -> in EXECUTE, alu_control = 010, 110, 000, 001, 111, 010. ALUWB has reg_dst=1 and reg_write=1.
// - op=000100 in BEQ state: zero=1 -> pc_en=1, pc_src=01, alu_control=110; zero=0 -> pc_en=0. op=000010 -> JUMP with pc_en=1, pc_src=10.
// - Unknown op=111111 -> DECODE then FETCH. Assert reset=0 while in MEMRD -> FETCH at the next posedge with mem_write=0 and reg_write=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - opcode and funct field constants
//   - ALU control codes and the internal aluop encoding
//   - main FSM state encodings
//   - control-word struct used by the output decode
//   - funct_to_alu helper shared by the ALU decoder
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Internal aluop: tells the ALU decoder how to pick the operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // Main FSM state encodings (12 of 16 codes used)
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // Per-state control word produced by the Moore output decode
    typedef struct packed {
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    // Map an R-type funct field to an ALU control code; unknown functs get dflt
    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct,
                                                input logic [2:0] dflt);
        logic [2:0] code;
        case (funct)
            FN_ADD:  code = ALU_ADD;
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_SLT:  code = ALU_SLT;
            default: code = dflt;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_controller_alu_decoder
// Purely combinational ALU decoder: turns the FSM's aluop plus the instruction
// funct field into the 3-bit ALU control code.
// Ports:
//   aluop       in  2  00 add, 01 sub, 10 decode funct, 11 add
//   funct       in  6  instr[5:0]
//   alu_control out 3  ALU operation code
// -----------------------------------------------------------------------------
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
#(
    parameter logic [2:0] ALU_DEFAULT = 3'b010
) (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Select the ALU operation from aluop, consulting funct only for R-type
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_to_alu(funct, ALU_DEFAULT);
            ALUOP_RSVD:  alu_control = ALU_ADD;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control unit of the multicycle MIPS core. A Moore main FSM sequences each
// instruction (lw, sw, R-type, beq, addi, j) through its cycles and drives the
// datapath enables and mux selects; a combinational ALU decoder produces the
// ALU operation.
// Ports:
//   clk          in   1  single clock, posedge
//   reset        in   1  synchronous active-low; forces FETCH
//   op           in   6  instr[31:26]
//   funct        in   6  instr[5:0]
//   zero         in   1  ALU result == 0
//   i_or_d       out  1  memory address: 0 PC, 1 ALUOut
//   mem_write    out  1  data memory write enable
//   ir_write     out  1  instruction register load
//   reg_dst      out  1  write address: 0 rt, 1 rd
//   mem_to_reg   out  1  write data: 0 ALUOut, 1 Data
//   reg_write    out  1  register file write enable
//   alu_src_a    out  1  ALU A: 0 PC, 1 A reg
//   alu_src_b    out  2  ALU B: B / 4 / SignImm / SignImm<<2
//   pc_src       out  2  next PC: ALUResult / ALUOut / jump target
//   pc_en        out  1  PC load = pc_write | (branch & zero)
//   alu_control  out  3  ALU operation
// -----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int         STATE_W     = 4,
    parameter logic [2:0] ALU_DEFAULT = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [2:0] alu_control
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl_s;

    // Next-state logic; op is only looked at in DECODE and MEMADR
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_BEQ:   state_d = S_BEQ;
                    OP_ADDI:  state_d = S_ADDIEXEC;
                    OP_J:     state_d = S_JUMP;
                    // Unsupported opcodes are dropped and the core refetches
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_MEMWB,
            S_MEMWR,
            S_ALUWB,
            S_ADDIWB,
            S_BEQ,
            S_JUMP:     state_d = S_FETCH;
            // Unused encodings recover to FETCH
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode: everything not set for a state stays 0
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.ir_write  = 1'b1;
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                ctrl_s.alu_src_b = 2'b11;
            end
            S_MEMADR,
            S_ADDIEXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl_s.i_or_d = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.i_or_d    = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_s.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.aluop     = ALUOP_SUB;
                ctrl_s.pc_src    = 2'b01;
                ctrl_s.branch    = 1'b1;
            end
            S_JUMP: begin
                ctrl_s.pc_src   = 2'b10;
                ctrl_s.pc_write = 1'b1;
            end
            default: begin
                ctrl_s = '0;
            end
        endcase
    end

    multicycle_controller_alu_decoder #(
        .ALU_DEFAULT (ALU_DEFAULT)
    ) u_alu_decoder (
        .aluop       (ctrl_s.aluop),
        .funct       (funct),
        .alu_control (alu_control)
    );

    assign i_or_d     = ctrl_s.i_or_d;
    assign mem_write  = ctrl_s.mem_write;
    assign ir_write   = ctrl_s.ir_write;
    assign reg_dst    = ctrl_s.reg_dst;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign reg_write  = ctrl_s.reg_write;
    assign alu_src_a  = ctrl_s.alu_src_a;
    assign alu_src_b  = ctrl_s.alu_src_b;
    assign pc_src     = ctrl_s.pc_src;
    // Branch is taken in the BEQ cycle itself when the subtraction is zero
    assign pc_en      = ctrl_s.pc_write | (ctrl_s.branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Randomized self-checking bench. A reference model turns each opcode into the
// list of instruction phases it must pass through and gives the expected
// control vector for each phase directly from the instruction-set behaviour.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] alu_control;

    int checks   = 0;
    int failures = 0;

    // Phase labels used by the reference model
    localparam int PH_FETCH   = 0;
    localparam int PH_DECODE  = 1;
    localparam int PH_MEMADR  = 2;
    localparam int PH_MEMRD   = 3;
    localparam int PH_MEMWB   = 4;
    localparam int PH_MEMWR   = 5;
    localparam int PH_EXECUTE = 6;
    localparam int PH_ALUWB   = 7;
    localparam int PH_BEQ     = 8;
    localparam int PH_ADDIEX  = 9;
    localparam int PH_ADDIWB  = 10;
    localparam int PH_JUMP    = 11;

    int plan[$];

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .i_or_d      (i_or_d),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .alu_control (alu_control)
    );

    always #5 clk = ~clk;

    wire [14:0] obs = {i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                       alu_src_a, alu_src_b, pc_src, pc_en, alu_control};

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // R-type operation table
    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector for a phase, given the live zero/funct inputs
    function automatic logic [14:0] expect_vec(input int ph, input logic z, input logic [5:0] f);
        logic iod = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0, m2r = 1'b0, rw = 1'b0;
        logic asa = 1'b0, pcw = 1'b0, br = 1'b0;
        logic [1:0] asb = 2'b00, pcs = 2'b00;
        logic [2:0] alu = 3'b010;
        case (ph)
            PH_FETCH:   begin irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
            PH_DECODE:  begin asb = 2'b11; end
            PH_MEMADR,
            PH_ADDIEX:  begin asa = 1'b1; asb = 2'b10; end
            PH_MEMRD:   begin iod = 1'b1; end
            PH_MEMWR:   begin iod = 1'b1; mw = 1'b1; end
            PH_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
            PH_EXECUTE: begin asa = 1'b1; alu = rtype_alu(f); end
            PH_ALUWB:   begin rw = 1'b1; rd = 1'b1; end
            PH_ADDIWB:  begin rw = 1'b1; end
            PH_BEQ:     begin asa = 1'b1; alu = 3'b110; pcs = 2'b01; br = 1'b1; end
            PH_JUMP:    begin pcs = 2'b10; pcw = 1'b1; end
            default:    begin end
        endcase
        return {iod, mw, irw, rd, m2r, rw, asa, asb, pcs, pcw | (br & z), alu};
    endfunction

    // Phases an instruction visits, FETCH first
    task automatic build_plan(input logic [5:0] o);
        plan.delete();
        plan.push_back(PH_FETCH);
        plan.push_back(PH_DECODE);
        case (o)
            6'b100011: begin plan.push_back(PH_MEMADR); plan.push_back(PH_MEMRD); plan.push_back(PH_MEMWB); end
            6'b101011: begin plan.push_back(PH_MEMADR); plan.push_back(PH_MEMWR); end
            6'b000000: begin plan.push_back(PH_EXECUTE); plan.push_back(PH_ALUWB); end
            6'b000100: plan.push_back(PH_BEQ);
            6'b001000: begin plan.push_back(PH_ADDIEX); plan.push_back(PH_ADDIWB); end
            6'b000010: plan.push_back(PH_JUMP);
            default:   begin end
        endcase
    endtask

    function automatic logic [5:0] pick_funct();
        logic [5:0] pool [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
        return 6'($urandom);
    endfunction

    // Run one instruction from its FETCH cycle. zmode: -1 random, else fixed zero.
    // abort_at >= 0 pulls reset low in that phase and checks the FETCH recovery.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] ffix, input bit frand,
                             input int zmode, input int abort_at, input string tag);
        build_plan(o);
        for (int i = 0; i < plan.size(); i++) begin
            if (i > 0) @(posedge clk);
            #1;
            op    = o;
            zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            funct = frand ? pick_funct() : ffix;
            #1;
            check_eq($sformatf("%s_ph%0d_z%0d_f%b", tag, plan[i], zero, funct),
                     obs, expect_vec(plan[i], zero, funct));
            if (i == abort_at) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
                #1;
                check_eq($sformatf("%s_reset_recover", tag), obs, expect_vec(PH_FETCH, zero, funct));
                check_eq($sformatf("%s_no_writes", tag), {13'd0, mem_write, reg_write}, 15'd0);
                return;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [5:0] fsweep [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        logic [5:0] ops    [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        reset = 1'b0;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // First cycle after release is FETCH; continue straight into a lw
        run_instr(6'b100011, 6'b0, 1'b1, -1, -1, "reset_then_lw");
        run_instr(6'b101011, 6'b0, 1'b1, -1, -1, "sw");
        for (int k = 0; k < 6; k++) begin
            run_instr(6'b000000, fsweep[k], 1'b0, -1, -1, $sformatf("rtype%0d", k));
        end
        run_instr(6'b000100, 6'b0, 1'b1, 1, -1, "beq_taken");
        run_instr(6'b000100, 6'b0, 1'b1, 0, -1, "beq_not_taken");
        run_instr(6'b000010, 6'b0, 1'b1, -1, -1, "jump");
        run_instr(6'b001000, 6'b0, 1'b1, -1, -1, "addi");
        run_instr(6'b111111, 6'b0, 1'b1, -1, -1, "unknown_op");
        // Reset asserted while in MEMRD (phase index 3 of lw)
        run_instr(6'b100011, 6'b0, 1'b1, -1, 3, "lw_abort");
        for (int n = 0; n < 200; n++) begin
            logic [5:0] o;
            if ($urandom_range(0, 3) == 0) o = 6'($urandom);
            else o = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 19) == 0)
                run_instr(o, 6'b0, 1'b1, -1, int'($urandom_range(0, 1)), $sformatf("rnd%0d_abort", n));
            else
                run_instr(o, 6'b0, 1'b1, -1, -1, $sformatf("rnd%0d", n));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
